// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: per-digit dwell with anti-ghosting dead time,
// decimal points, digit enables, leading-zero blanking and frame-coherent input snapshots.
module ssd_scan_driver #(
    parameter  int NUM_DIGITS  = 8,
    parameter  int SCAN_PERIOD = 262144,
    parameter  int DEAD_CYCLES = 1024,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W       = $clog2(SCAN_PERIOD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_en,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              cathodes,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_done
);

    // Segment pattern abcdefg, active-low.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    first;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_en;
    logic                    snap_lz;

    logic                    slot_end;
    logic                    frame_end;
    logic [IDX_W-1:0]        hi;
    logic [3:0]              nib;
    logic                    lz_blank;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              cath_next;

    assign slot_end  = (cnt == CNT_W'(SCAN_PERIOD - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign scan_idx  = idx;

    // Highest nonzero digit of the frozen frame sets the leading-zero boundary.
    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (snap_digits[4*i +: 4] != 4'h0) begin
                hi = IDX_W'(i);
            end
        end
    end

    always_comb begin
        nib       = snap_digits[{idx, 2'b00} +: 4];
        lz_blank  = snap_lz && (idx > hi);
        lit       = (cnt >= CNT_W'(DEAD_CYCLES)) && snap_en[idx] && !lz_blank;
        an_next   = '1;
        cath_next = 8'hFF;
        if (lit) begin
            an_next   = ~(NUM_DIGITS'(1) << idx);
            cath_next = {glyph(nib), ~snap_dp[idx]};
        end
    end

    // Inputs are frozen only at the first post-reset edge and at frame wraps,
    // so a frame never shows a mix of old and new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            first       <= 1'b1;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_en     <= '0;
            snap_lz     <= 1'b0;
            an          <= '1;
            cathodes    <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            first <= 1'b0;
            if (first || frame_end) begin
                snap_digits <= digits;
                snap_dp     <= dp_en;
                snap_en     <= digit_en;
                snap_lz     <= lz_en;
            end
            an         <= an_next;
            cathodes   <= cath_next;
            frame_done <= frame_end;
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver (4 digits, 8-cycle slots, 2 dead cycles).
module tb_ssd_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] cath;
        logic [1:0] sidx;
        logic       fd;
    } exp_t;

    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic [3:0]  digit_en;
    logic        lz_en;
    logic [3:0]  an;
    logic [7:0]  cathodes;
    logic [1:0]  scan_idx;
    logic        frame_done;

    int passed = 0;
    int total  = 0;

    exp_t sb[$];

    ssd_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_PERIOD(8),
        .DEAD_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .dp_en     (dp_en),
        .digit_en  (digit_en),
        .lz_en     (lz_en),
        .an        (an),
        .cathodes  (cathodes),
        .scan_idx  (scan_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: predicts the registered outputs of every edge.
    int          m_cnt = 0, m_idx = 0;
    bit          m_first = 1'b1;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp = '0, m_en = '0;
    logic        m_lz = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   hi, nib;
        bit   lit, wrap;
        if (rst) begin
            e = '{an: 4'hF, cath: 8'hFF, sidx: 2'd0, fd: 1'b0};
            m_cnt = 0; m_idx = 0; m_first = 1'b1;
            m_dig = '0; m_dp = '0; m_en = '0; m_lz = 1'b0;
        end else begin
            hi = 0;
            for (int i = 0; i < 4; i++)
                if (((m_dig >> (4 * i)) & 16'hF) != 0) hi = i;
            nib  = int'((m_dig >> (4 * m_idx)) & 16'hF);
            lit  = (m_cnt >= 2) && m_en[m_idx] && !(m_lz && m_idx > hi);
            wrap = (m_cnt == 7) && (m_idx == 3);
            e.an   = lit ? ~(4'b0001 << m_idx) : 4'hF;
            e.cath = lit ? {GLYPH[nib], ~m_dp[m_idx]} : 8'hFF;
            e.fd   = wrap;
            if (m_first || wrap) begin
                m_dig = digits; m_dp = dp_en; m_en = digit_en; m_lz = lz_en;
            end
            m_first = 1'b0;
            if (m_cnt == 7) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            e.sidx = 2'(m_idx);
        end
        sb.push_back(e);
    end

    task automatic next_cycle(output exp_t e, output bit ok);
        @(negedge clk);
        ok = (sb.size() > 0);
        e  = '0;
        if (ok) e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e; bit ok;
        rst = 1'b1; digits = 16'h1234; dp_en = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL reset_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
        end
        total++;
        if ({an, cathodes, scan_idx, frame_done} !== {4'hF, 8'hFF, 2'd0, 1'b0})
            $display("FAIL reset_values: got %h expected %h", {an, cathodes, scan_idx, frame_done}, {4'hF, 8'hFF, 2'd0, 1'b0});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e; bit ok; int fd_cnt;
        fd_cnt = 0;
        for (int j = 0; j < 64; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL scan_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
            if (frame_done === 1'b1) fd_cnt++;
            if (j == 1 || j == 2 || j == 10 || j == 18 || j == 26) begin
                logic [11:0] want;
                case (j)
                    1:       want = {4'b1111, 8'hFF};
                    2:       want = {4'b1110, 7'b1001100, 1'b1};
                    10:      want = {4'b1101, 7'b0000110, 1'b1};
                    18:      want = {4'b1011, 7'b0010010, 1'b1};
                    default: want = {4'b0111, 7'b1001111, 1'b1};
                endcase
                total++;
                if ({an, cathodes} !== want)
                    $display("FAIL scan_digit cyc %0d: got %h expected %h", j, {an, cathodes}, want);
                else passed++;
            end
        end
        total++;
        if (fd_cnt != 2) $display("FAIL frame_done_count: got %0d expected 2", fd_cnt);
        else passed++;
    endtask

    task automatic test_dp_enable();
        exp_t e; bit ok;
        dp_en = 4'b0010; digit_en = 4'b1011;
        for (int j = 0; j < 64; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL dp_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
            if (j >= 42 && j <= 47) begin
                total++;
                if (an !== 4'b1101 || cathodes[0] !== 1'b0)
                    $display("FAIL dp_slot1 cyc %0d: got %b/%b expected 1101/0", j, an, cathodes[0]);
                else passed++;
            end
            if (j >= 48 && j <= 55) begin
                total++;
                if (an !== 4'b1111)
                    $display("FAIL disabled_slot2 cyc %0d: got %b expected 1111", j, an);
                else passed++;
            end
        end
    endtask

    task automatic test_leading_zero();
        exp_t e; bit ok;
        dp_en = 4'h0; digit_en = 4'hF; lz_en = 1'b1;
        for (int pass_n = 0; pass_n < 2; pass_n++) begin
            digits = (pass_n == 0) ? 16'h0070 : 16'h0000;
            for (int j = 0; j < 64; j++) begin
                next_cycle(e, ok);
                total++;
                if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                    $display("FAIL lz_sb p%0d cyc %0d: got %h expected %h", pass_n, j, {an, cathodes, scan_idx, frame_done}, e);
                else passed++;
                if (j == 34 || j == 42 || j == 50 || j == 58) begin
                    logic [11:0] want;
                    want = {4'b1111, 8'hFF};
                    if (j == 34) want = {4'b1110, 7'b0000001, 1'b1};
                    if (j == 42 && pass_n == 0) want = {4'b1101, 7'b0001111, 1'b1};
                    total++;
                    if ({an, cathodes} !== want)
                        $display("FAIL lz_digit p%0d cyc %0d: got %h expected %h", pass_n, j, {an, cathodes}, want);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_snapshot();
        exp_t e; bit ok;
        digits = 16'h1111; lz_en = 1'b0;
        for (int j = 0; j < 96; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL snap_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
            if (j == 34 || j == 42 || j == 50 || j == 58 || j == 66) begin
                logic [11:0] want;
                case (j)
                    34:      want = {4'b1110, 7'b1001111, 1'b1};
                    42:      want = {4'b1101, 7'b1001111, 1'b1};
                    50:      want = {4'b1011, 7'b1001111, 1'b1};
                    58:      want = {4'b0111, 7'b1001111, 1'b1};
                    default: want = {4'b1110, 7'b0010010, 1'b1};
                endcase
                total++;
                if ({an, cathodes} !== want)
                    $display("FAIL snap_digit cyc %0d: got %h expected %h", j, {an, cathodes}, want);
                else passed++;
            end
            if (j == 42) digits = 16'h2222;
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; bit ok;
        // Entered at cycle 96 of the previous task's count, i.e. slot 0 of a frame.
        for (int j = 0; j < 19; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL mrst_pre_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
        end
        total++;
        if (an !== 4'b1011) $display("FAIL mrst_slot2_lit: got %b expected 1011", an);
        else passed++;
        rst = 1'b1;
        next_cycle(e, ok);
        total++;
        if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
            $display("FAIL mrst_sb: got %h expected %h", {an, cathodes, scan_idx, frame_done}, e);
        else passed++;
        total++;
        if ({an, cathodes, scan_idx, frame_done} !== {4'hF, 8'hFF, 2'd0, 1'b0})
            $display("FAIL mrst_values: got %h expected %h", {an, cathodes, scan_idx, frame_done}, {4'hF, 8'hFF, 2'd0, 1'b0});
        else passed++;
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            next_cycle(e, ok);
            total++;
            if (!ok || {an, cathodes, scan_idx, frame_done} !== e)
                $display("FAIL mrst_post_sb cyc %0d: got %h expected %h", j, {an, cathodes, scan_idx, frame_done}, e);
            else passed++;
            if (j == 2) begin
                total++;
                if ({an, cathodes} !== {4'b1110, 7'b0010010, 1'b1})
                    $display("FAIL mrst_restart: got %h expected %h", {an, cathodes}, {4'b1110, 7'b0010010, 1'b1});
                else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; digits = 16'h1234; dp_en = 4'h0; digit_en = 4'hF; lz_en = 1'b0;
        test_reset();
        test_scan();
        test_dp_enable();
        test_leading_zero();
        test_snapshot();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
